// File: rtl/cache_param_pkg.sv
// ----------------------------------------------------------------------------
// cache_param_pkg
//   Shared types and constants for the far-memory controller (cache_fm_ctrl)
//   and its request queue (cache_fm_fifo).
//   Contents: FM_* widths, request/response payload structs, queue entry
//   struct and the controller state enum.
// ----------------------------------------------------------------------------
package cache_param_pkg;

    localparam int unsigned FM_LINE_W         = 128;
    localparam int unsigned FM_LINE_ADRS_W    = 24;
    localparam int unsigned FM_MEM_ADRS_W     = 10;
    localparam int unsigned FM_TQ_ID_W        = 2;
    localparam int unsigned FM_FIFO_DEPTH     = 4;
    localparam int unsigned FM_ACCESS_LATENCY = 8;

    // Write-back (dirty evict) request from q3
    typedef struct packed {
        logic                      valid;
        logic [FM_LINE_ADRS_W-1:0] line_adrs;
        logic [FM_LINE_W-1:0]      data;
    } t_fm_wr_req;

    // Fill-read (miss) request from q3
    typedef struct packed {
        logic                      valid;
        logic [FM_LINE_ADRS_W-1:0] line_adrs;
        logic [FM_TQ_ID_W-1:0]     tq_id;
    } t_fm_rd_req;

    // Fill response back to the cache TQ
    typedef struct packed {
        logic                      valid;
        logic [FM_LINE_ADRS_W-1:0] line_adrs;
        logic [FM_LINE_W-1:0]      data;
        logic [FM_TQ_ID_W-1:0]     tq_id;
    } t_fm_rd_rsp;

    // Request queue entry (reads and writes share one in-order queue)
    typedef struct packed {
        logic                      is_wr;
        logic [FM_LINE_ADRS_W-1:0] line_adrs;
        logic [FM_LINE_W-1:0]      data;
        logic [FM_TQ_ID_W-1:0]     tq_id;
    } t_fm_req;

    typedef enum logic [1:0] {
        FM_IDLE   = 2'd0,
        FM_ACCESS = 2'd1,
        FM_RESP   = 2'd2
    } t_fm_state;

endpackage

// File: rtl/cache_fm_fifo.sv
// ----------------------------------------------------------------------------
// cache_fm_fifo
//   In-order request queue for the far-memory controller. Accepts 0..2
//   pushes per cycle (slot allocation is decided by the parent) and one pop.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     i_push_cnt          number of entries pushed this cycle (0..2)
//     i_push_data0/1      first / second pushed entry
//     i_pop               remove the head entry
//     o_head_c            head entry (combinational read)
//     o_count             occupancy
//     o_full_c/o_empty_c  occupancy flags
// ----------------------------------------------------------------------------
module cache_fm_fifo
    import cache_param_pkg::*;
#(
    parameter int unsigned DEPTH = FM_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 i_push_cnt,
    input  t_fm_req                    i_push_data0,
    input  t_fm_req                    i_push_data1,
    input  logic                       i_pop,
    output t_fm_req                    o_head_c,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full_c,
    output logic                       o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    t_fm_req         r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    // Storage array is not reset; only pointers and occupancy are
    always_ff @(posedge clk) begin
        if (i_push_cnt != 2'd0) begin
            r_mem[r_wptr] <= i_push_data0;
        end
        if (i_push_cnt == 2'd2) begin
            r_mem[r_wptr + AW'(1)] <= i_push_data1;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_push_cnt);
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop);
        end
    end

    assign o_head_c  = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/cache_fm_ctrl.sv
// ----------------------------------------------------------------------------
// cache_fm_ctrl
//   Far-memory controller downstream of the cache pipe. Queues q3 write-back
//   and fill-read requests in arrival order and services them one at a time
//   against a fixed-latency line-granular backing store. Fill data returns
//   with the originating TQ id as a single-cycle response pulse.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     cache2fm_wr_req_q3    {valid, line_adrs, data} write-back
//     cache2fm_rd_req_q3    {valid, line_adrs, tq_id} fill read
//     fm2cache_rd_rsp       {valid, line_adrs, data, tq_id} fill response
//     fm_busy               request in service or queue non-empty
//     fm_overflow           sticky: a request was dropped on a full queue
//     fm_rd_cnt/fm_wr_cnt   completed read/write counters
//                           (only when CACHE_FM_STATS_EN is defined)
// ----------------------------------------------------------------------------
module cache_fm_ctrl
    import cache_param_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = FM_FIFO_DEPTH,
    parameter int unsigned ACCESS_LATENCY = FM_ACCESS_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  t_fm_wr_req  cache2fm_wr_req_q3,
    input  t_fm_rd_req  cache2fm_rd_req_q3,
    output t_fm_rd_rsp  fm2cache_rd_rsp,
    output logic        fm_busy,
    output logic        fm_overflow
`ifdef CACHE_FM_STATS_EN
    ,
    output logic [31:0] fm_rd_cnt,
    output logic [31:0] fm_wr_cnt
`endif
);

    localparam int unsigned MEM_ADRS_W = FM_MEM_ADRS_W;
    localparam int unsigned MEM_LINES  = 2 ** MEM_ADRS_W;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W      = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    t_fm_state           r_state;
    t_fm_state           w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    t_fm_req             r_req;
    t_fm_rd_rsp          r_rsp;
    logic                r_overflow;
    logic [FM_LINE_W-1:0] r_store [MEM_LINES];

    logic                w_pop;
    logic                w_store_we;
    logic                w_rsp_load;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [CW-1:0]       w_free;
    logic [1:0]          w_push_cnt;
    t_fm_req             w_wr_ent;
    t_fm_req             w_rd_ent;
    t_fm_req             w_push_data0;
    t_fm_req             w_head;
    logic [CW-1:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic [MEM_ADRS_W-1:0] w_idx;

    cache_fm_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_cnt   (w_push_cnt),
        .i_push_data0 (w_push_data0),
        .i_push_data1 (w_rd_ent),
        .i_pop        (w_pop),
        .o_head_c     (w_head),
        .o_count      (w_count),
        .o_full_c     (w_full),
        .o_empty_c    (w_empty)
    );

    // Enqueue arbitration: the write takes the first free slot, the read
    // only gets a slot if one remains; a same-cycle pop frees a slot first.
    always_comb begin
        w_wr_ent           = '0;
        w_wr_ent.is_wr     = 1'b1;
        w_wr_ent.line_adrs = cache2fm_wr_req_q3.line_adrs;
        w_wr_ent.data      = cache2fm_wr_req_q3.data;

        w_rd_ent           = '0;
        w_rd_ent.line_adrs = cache2fm_rd_req_q3.line_adrs;
        w_rd_ent.tq_id     = cache2fm_rd_req_q3.tq_id;

        w_free   = CW'(FIFO_DEPTH) - w_count + CW'(w_pop);
        w_wr_acc = cache2fm_wr_req_q3.valid && (!w_full || w_pop);
        w_rd_acc = cache2fm_rd_req_q3.valid &&
                   (w_free >= (w_wr_acc ? CW'(2) : CW'(1)));

        w_push_cnt   = 2'(w_wr_acc) + 2'(w_rd_acc);
        w_push_data0 = w_wr_acc ? w_wr_ent : w_rd_ent;
    end

    assign w_idx = r_req.line_adrs[MEM_ADRS_W-1:0];

    // Next-state logic: one request in service at a time
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_store_we  = 1'b0;
        w_rsp_load  = 1'b0;
        case (r_state)
            FM_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = CNT_W'(ACCESS_LATENCY - 1);
                    w_state_nxt = FM_ACCESS;
                end
            end
            FM_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_req.is_wr) begin
                    w_store_we  = 1'b1;
                    w_state_nxt = FM_IDLE;
                end else begin
                    w_rsp_load  = 1'b1;
                    w_state_nxt = FM_RESP;
                end
            end
            FM_RESP: begin
                w_state_nxt = FM_IDLE;
            end
            default: begin
                w_state_nxt = FM_IDLE;
            end
        endcase
    end

    // State, in-service request, response register and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FM_IDLE;
            r_cnt      <= '0;
            r_req      <= '0;
            r_rsp      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop) begin
                r_req <= w_head;
            end
            // Response fields persist between pulses; only valid drops
            if (w_rsp_load) begin
                r_rsp.valid     <= 1'b1;
                r_rsp.line_adrs <= r_req.line_adrs;
                r_rsp.data      <= r_store[w_idx];
                r_rsp.tq_id     <= r_req.tq_id;
            end else begin
                r_rsp.valid     <= 1'b0;
            end
            if ((cache2fm_wr_req_q3.valid && !w_wr_acc) ||
                (cache2fm_rd_req_q3.valid && !w_rd_acc)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Backing store survives reset
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            r_store[w_idx] <= r_req.data;
        end
    end

    assign fm2cache_rd_rsp = r_rsp;
    assign fm_overflow     = r_overflow;
    assign fm_busy         = (r_state != FM_IDLE) || !w_empty;

`ifdef CACHE_FM_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Completion counters, free-running with natural wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (r_state == FM_RESP) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_store_we) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign fm_rd_cnt = r_rd_cnt;
    assign fm_wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_cache_fm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cache_fm_ctrl
//   Directed bench for cache_fm_ctrl: a table of single-cycle transactions
//   with expected fill data and latency, plus hand sequences for queue
//   overflow, reset mid-access and (with CACHE_FM_STATS_EN) the counters.
// ----------------------------------------------------------------------------
module tb_cache_fm_ctrl;
    import cache_param_pkg::*;

    typedef struct {
        logic                      do_wr;
        logic [FM_LINE_ADRS_W-1:0] wr_adrs;
        logic [FM_LINE_W-1:0]      wr_data;
        logic                      do_rd;
        logic [FM_LINE_ADRS_W-1:0] rd_adrs;
        logic [FM_TQ_ID_W-1:0]     tq;
        logic [FM_LINE_W-1:0]      exp_data;
        int                        exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    t_fm_wr_req wr_req;
    t_fm_rd_req rd_req;
    t_fm_rd_rsp rsp;
    logic       busy;
    logic       ovf;
`ifdef CACHE_FM_STATS_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_fm_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cache2fm_wr_req_q3 (wr_req),
        .cache2fm_rd_req_q3 (rd_req),
        .fm2cache_rd_rsp    (rsp),
        .fm_busy            (busy),
        .fm_overflow        (ovf)
`ifdef CACHE_FM_STATS_EN
        ,
        .fm_rd_cnt          (rd_cnt),
        .fm_wr_cnt          (wr_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one transaction for one cycle, then watch until the controller
    // drains, checking response count, latency and payload.
    task automatic run_vec(input vec_t v, input string nm);
        int         t0;
        int         n;
        int         lat;
        bit         done;
        t_fm_rd_rsp got;
        n    = 0;
        lat  = 0;
        done = 1'b0;
        got  = '0;
        @(negedge clk);
        wr_req = '{v.do_wr, v.wr_adrs, v.wr_data};
        rd_req = '{v.do_rd, v.rd_adrs, v.tq};
        t0 = cyc;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                wr_req = '0;
                rd_req = '0;
            end
            if (rsp.valid) begin
                n++;
                if (n == 1) begin
                    lat = cyc - t0;
                    got = rsp;
                end
            end
            if (!busy) done = 1'b1;
        end
        chk({nm, "_drained"}, 128'(done), 128'(1));
        chk({nm, "_rsp_cnt"}, 128'(n), 128'(v.do_rd ? 1 : 0));
        if (v.do_rd) begin
            chk({nm, "_lat"},  128'(lat), 128'(v.exp_lat));
            chk({nm, "_adrs"}, 128'(got.line_adrs), 128'(v.rd_adrs));
            chk({nm, "_data"}, got.data, v.exp_data);
            chk({nm, "_tq"},   128'(got.tq_id), 128'(v.tq));
        end
    endtask

    initial begin
        vec_t                  w;
        int                    n;
        int                    nbusy;
        bit                    done;
        logic [FM_LINE_ADRS_W-1:0] got_adrs [8];
        logic [FM_LINE_W-1:0]      got_data [8];
        logic [FM_TQ_ID_W-1:0]     got_tq   [8];

        //          wr    wr_adrs       wr_data                                 rd    rd_adrs       tq    exp_data                                lat
        vecs[0] = '{1'b1, 24'h000005, {16{8'hA5}},                            1'b0, 24'h000000, 2'd0, 128'h0,                                 0};
        vecs[1] = '{1'b0, 24'h000000, 128'h0,                                 1'b1, 24'h000005, 2'd2, {16{8'hA5}},                            10};
        vecs[2] = '{1'b1, 24'h000007, 128'h1234,                              1'b1, 24'h000007, 2'd1, 128'h1234,                              19};
        vecs[3] = '{1'b1, 24'h000400, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 24'h000000, 2'd0, 128'h0,                       0};
        vecs[4] = '{1'b0, 24'h000000, 128'h0,                                 1'b1, 24'h000000, 2'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 10};
        vecs[5] = '{1'b1, 24'h0007FF, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, 1'b1, 24'h000BFF, 2'd0, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, 19};
        vecs[6] = '{1'b0, 24'h000000, 128'h0,                                 1'b1, 24'h000400, 2'd1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 10};

        wr_req = '0;
        rd_req = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 128'(rsp.valid), 128'(0));
        chk("rst_rsp_adrs",  128'(rsp.line_adrs), 128'(0));
        chk("rst_rsp_data",  rsp.data, 128'(0));
        chk("rst_rsp_tq",    128'(rsp.tq_id), 128'(0));
        chk("rst_busy",      128'(busy), 128'(0));
        chk("rst_ovf",       128'(ovf), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        chk("no_ovf_yet", 128'(ovf), 128'(0));

        // Overflow: preload lines 20..25, then 6 back-to-back reads
        for (int i = 0; i < 6; i++) begin
            w = '{1'b1, 24'(20 + i), 128'(100 + i), 1'b0, 24'h0, 2'd0, 128'h0, 0};
            run_vec(w, $sformatf("pre%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_req = '{1'b1, 24'(20 + i), 2'(i)};
        end
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 150 && !done; k++) begin
            @(negedge clk);
            if (k == 0) rd_req = '0;
            if (rsp.valid) begin
                if (n < 8) begin
                    got_adrs[n] = rsp.line_adrs;
                    got_data[n] = rsp.data;
                    got_tq[n]   = rsp.tq_id;
                end
                n++;
            end
            if (!busy) done = 1'b1;
        end
        chk("ovf_drained", 128'(done), 128'(1));
        chk("ovf_rsp_cnt", 128'(n), 128'(5));
        for (int i = 0; i < 5 && i < n; i++) begin
            chk($sformatf("ovf_adrs%0d", i), 128'(got_adrs[i]), 128'(20 + i));
            chk($sformatf("ovf_data%0d", i), got_data[i], 128'(100 + i));
            chk($sformatf("ovf_tq%0d", i),   128'(got_tq[i]), 128'(i % 4));
        end
        chk("ovf_set", 128'(ovf), 128'(1));
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 128'(ovf), 128'(1));

        // Reset during ACCESS with two requests queued
        w = '{1'b1, 24'h00001E, 128'h5555_AAAA_5555_AAAA_1357_9BDF_2468_ACE0, 1'b0, 24'h0, 2'd0, 128'h0, 0};
        run_vec(w, "pre_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_req = '{1'b1, 24'(30 + i), 2'(i)};
        end
        @(negedge clk);
        rd_req = '0;
        @(negedge clk);
        chk("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("arst_busy",  128'(busy), 128'(0));
        chk("arst_valid", 128'(rsp.valid), 128'(0));
        chk("arst_ovf",   128'(ovf), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        n     = 0;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp.valid) n++;
            if (busy) nbusy++;
        end
        chk("post_rst_rsp",  128'(n), 128'(0));
        chk("post_rst_busy", 128'(nbusy), 128'(0));
        w = '{1'b0, 24'h0, 128'h0, 1'b1, 24'h00001E, 2'd3, 128'h5555_AAAA_5555_AAAA_1357_9BDF_2468_ACE0, 10};
        run_vec(w, "post_rst_rd");

`ifdef CACHE_FM_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("st_rd_zero", 128'(rd_cnt), 128'(0));
        chk("st_wr_zero", 128'(wr_cnt), 128'(0));
        for (int i = 0; i < 3; i++) begin
            w = '{1'b1, 24'(40 + i), 128'(7 + i), 1'b0, 24'h0, 2'd0, 128'h0, 0};
            run_vec(w, $sformatf("st_wr%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            w = '{1'b0, 24'h0, 128'h0, 1'b1, 24'(40 + i), 2'(i), 128'(7 + i), 10};
            run_vec(w, $sformatf("st_rd%0d", i));
        end
        chk("st_wr_cnt", 128'(wr_cnt), 128'(3));
        chk("st_rd_cnt", 128'(rd_cnt), 128'(2));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("st_rd_rst", 128'(rd_cnt), 128'(0));
        chk("st_wr_rst", 128'(wr_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
